// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the parity helper.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam logic [5:0] ST_IDLE      = 6'b000001;
   localparam logic [5:0] ST_START     = 6'b000010;
   localparam logic [5:0] ST_DATA      = 6'b000100;
   localparam logic [5:0] ST_PARITY    = 6'b001000;
   localparam logic [5:0] ST_STOP      = 6'b010000;
   localparam logic [5:0] ST_WAIT_HIGH = 6'b100000;

   // Parity bit that makes a correct frame; unused upper data bits must be zero.
   function automatic logic parity_bit(input logic [8:0] data, input int mode);
      logic x;
      x = ^data;
      if (mode == PARITY_ODD) begin
         parity_bit = ~x;
      end else begin
         parity_bit = x;
      end
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: sample_tick at mid-bit, bit_end at wrap; clear restarts from zero.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
)(
   input  logic CLK100MHZ,
   input  logic reset,
   input  logic clear,
   output logic sample_tick,
   output logic bit_end
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise wrap at the end of the bit.
   always_comb begin
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end

   // Counter register.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sample_tick = (cnt_q == HALF);
   assign bit_end     = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: synchronised, majority-voted sampling with framing,
// parity, break and overrun detection, delivering words over a valid/ready handshake.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
)(
   input  logic                  CLK100MHZ,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  RXD,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_frame_err,
   output logic                  rx_parity_err,
   output logic                  rx_break,
   output logic                  rx_overrun,
   output logic                  busy
);

   localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
   localparam logic       STOP_LAST = (STOP_BITS == 2);

   logic [1:0] sync_q, sync_d;
   logic [2:0] hist_q, hist_d;
   logic rxs_s, maj_s, fall_s;
   logic [5:0] state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic stop_idx_q, stop_idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic fe_acc_q, fe_acc_d, pe_acc_q, pe_acc_d, stop0_low_q, stop0_low_d;
   logic load_s, load_fe_s, load_brk_s;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, brk_q, brk_d;
   logic ovr_q, ovr_d, busy_q, busy_d;
   logic clear_s, sample_tick_s, bit_end_s;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .CLK100MHZ   (CLK100MHZ),
      .reset       (reset),
      .clear       (clear_s),
      .sample_tick (sample_tick_s),
      .bit_end     (bit_end_s)
   );

   // Input synchroniser and sample history feeding the majority vote.
   always_comb begin
      sync_d = {sync_q[0], RXD};
      hist_d = {hist_q[1:0], sync_q[1]};
   end

   assign rxs_s   = sync_q[1];
   assign maj_s   = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
   assign fall_s  = hist_q[0] & ~rxs_s;
   assign clear_s = ~enable | (state_q == ST_IDLE) | (state_q == ST_WAIT_HIGH);

   // Frame state machine; a disabled receiver is held in IDLE and drops any partial frame.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      stop_idx_d  = stop_idx_q;
      shift_d     = shift_q;
      fe_acc_d    = fe_acc_q;
      pe_acc_d    = pe_acc_q;
      stop0_low_d = stop0_low_q;
      load_s      = 1'b0;
      load_fe_s   = 1'b0;
      load_brk_s  = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = fall_s ? ST_START : ST_IDLE;
            end
            ST_START: begin
               idx_d       = 4'd0;
               stop_idx_d  = 1'b0;
               fe_acc_d    = 1'b0;
               pe_acc_d    = 1'b0;
               stop0_low_d = 1'b0;
               if (sample_tick_s && maj_s) begin
                  state_d = ST_IDLE;
               end else if (bit_end_s) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_START;
               end
            end
            ST_DATA: begin
               if (sample_tick_s) begin
                  shift_d = {maj_s, shift_q[DATA_WIDTH-1:1]};
               end else begin
                  shift_d = shift_q;
               end
               if (bit_end_s && (idx_q == LAST_BIT)) begin
                  state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else if (bit_end_s) begin
                  idx_d = idx_q + 4'd1;
               end else begin
                  idx_d = idx_q;
               end
            end
            ST_PARITY: begin
               if (sample_tick_s) begin
                  pe_acc_d = (maj_s != parity_bit(9'(shift_q), PARITY_MODE));
               end else begin
                  pe_acc_d = pe_acc_q;
               end
               state_d = bit_end_s ? ST_STOP : ST_PARITY;
            end
            ST_STOP: begin
               // Leave at the final stop sample so back-to-back frames resynchronise.
               if (sample_tick_s && (stop_idx_q == STOP_LAST)) begin
                  load_s     = 1'b1;
                  load_fe_s  = fe_acc_q | ~maj_s;
                  load_brk_s = (shift_q == '0) && ((STOP_BITS == 1) ? ~maj_s : stop0_low_q);
                  state_d    = load_brk_s ? ST_WAIT_HIGH : ST_IDLE;
               end else if (sample_tick_s) begin
                  fe_acc_d    = ~maj_s;
                  stop0_low_d = ~maj_s;
               end else if (bit_end_s) begin
                  stop_idx_d = 1'b1;
               end else begin
                  state_d = ST_STOP;
               end
            end
            ST_WAIT_HIGH: begin
               state_d = rxs_s ? ST_IDLE : ST_WAIT_HIGH;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output word, flags and handshake; a frame arriving while the old word is unconsumed is dropped.
   always_comb begin
      data_d  = data_q;
      fe_d    = fe_q;
      pe_d    = pe_q;
      brk_d   = brk_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (load_s && (!valid_q || rx_ready)) begin
         data_d  = shift_q;
         fe_d    = load_fe_s;
         pe_d    = (PARITY_MODE != PARITY_NONE) && pe_acc_q;
         brk_d   = load_brk_s;
         valid_d = 1'b1;
      end else if (load_s) begin
         ovr_d = 1'b1;
      end else if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         sync_q      <= 2'b11;
         hist_q      <= 3'b111;
         state_q     <= ST_IDLE;
         idx_q       <= 4'd0;
         stop_idx_q  <= 1'b0;
         shift_q     <= '0;
         fe_acc_q    <= 1'b0;
         pe_acc_q    <= 1'b0;
         stop0_low_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         fe_q        <= 1'b0;
         pe_q        <= 1'b0;
         brk_q       <= 1'b0;
         ovr_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         hist_q      <= hist_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         stop_idx_q  <= stop_idx_d;
         shift_q     <= shift_d;
         fe_acc_q    <= fe_acc_d;
         pe_acc_q    <= pe_acc_d;
         stop0_low_q <= stop0_low_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         fe_q        <= fe_d;
         pe_q        <= pe_d;
         brk_q       <= brk_d;
         ovr_q       <= ovr_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign rx_frame_err  = fe_q;
   assign rx_parity_err = pe_q;
   assign rx_break      = brk_q;
   assign rx_overrun    = ovr_q;
   assign busy          = busy_q;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receive engine; the successor to the fixed 8N1 receiver. Supports:
- configurable data width, baud divisor, parity mode and stop-bit count;
- 2-flop input synchroniser, 3-sample majority voting and false-start rejection;
- framing, parity, break and overrun detection;
- valid/ready output handshake.

It sits between the RXD pad and the command/FIFO logic.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9, LSB first on the line
CLKS_PER_BIT, 868, CLK100MHZ cycles per bit (115200 baud), legal >= 8
PARITY_MODE, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, 1 or 2

Ports:
CLK100MHZ  input  1  system clock
reset  input  1  asynchronous, active-high
enable  input  1  receiver enable; low forces IDLE
RXD  input  1  asynchronous serial line, idle high
rx_data  output  DATA_WIDTH  received word, stable while rx_valid
rx_valid  output  1  word available
rx_ready  input  1  consumer accepts word when rx_valid && rx_ready
rx_frame_err  output  1  a stop bit sampled low; qualified by rx_valid
rx_parity_err  output  1  parity mismatch; qualified by rx_valid, always 0 when PARITY_MODE=0
rx_break  output  1  break: data all zero and first stop bit low; qualified by rx_valid
rx_overrun  output  1  one-cycle pulse: a completed frame was dropped
busy  output  1  high in any state other than IDLE

Behaviour:
Reset values:
- all outputs 0, FSM in IDLE;
- synchroniser flops 1; sample history 3'b111.

Input sampling:
- RXD passes through 2 flops to give rxs.
- A 3-entry history of rxs shifts every cycle.
- The bit value is the majority of that history.

Timing:
- Bit counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps.
- Sample point: counter == CLKS_PER_BIT/2 (integer division).

States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: an rxs 1->0 edge moves to START; counter cleared the same cycle.
- START: at the sample point, majority 1 is a false start: return to IDLE, no flags. Majority 0: at counter wrap go to DATA, bit index 0.
- DATA: sample each bit into the shift register LSB first. After bit DATA_WIDTH-1, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: compare the sampled bit with the parity computed over the data bits. Odd mode: XOR of data and parity bit must equal 1. Even mode: it must equal 0.
- STOP: sample STOP_BITS bits; any low sample sets the frame error.
- Leaving STOP: at the final stop sample (not at the bit end), go to IDLE. If the break condition holds, go to WAIT_HIGH instead. Early exit allows back-to-back frames.
- WAIT_HIGH: stay until rxs == 1, then go to IDLE.

Output delivery:
- One cycle after the final stop sample, the word and its error flags are presented together.
- If rx_valid is 0, or rx_valid && rx_ready in that same cycle: load rx_data and all error flags, set rx_valid=1 (it stays 1 on simultaneous consume+load).
- If rx_valid=1 and rx_ready=0 in that cycle: keep the old word and flags, drop the new frame, pulse rx_overrun for 1 cycle.

Handshake:
- rx_valid && rx_ready with no new load: rx_valid goes 0 the next cycle.
- Flags hold their last values but are meaningless while rx_valid=0.

enable:
- enable=0 forces IDLE next cycle and discards any partial frame.
- enable=0 does not touch rx_valid, rx_data or the flags; the handshake keeps working.
- enable rising while RXD is low: no start is detected until a fresh 1->0 edge.

Reset mid-frame: everything returns to the reset values immediately; any pending word is lost.

Latency: start edge on the pin to rx_valid high = 2 (sync) + CLKS_PER_BIT*(DATA_WIDTH + parity + STOP_BITS) + CLKS_PER_BIT/2 + 2 cycles, ±1 for the majority window.

Decomposition:
Shared package uart_pkg:
- PARITY_NONE/ODD/EVEN constants;
- rx state encoding (one-hot, 6 bits);
- function computing the parity bit.

Sub-module uart_bit_timer holds the bit counter. Outputs are a sample_tick at the sample point and a bit_end at wrap. Clear input restarts it from 0. The same sub-module is reused by the future transmitter.

Test Plan:
Run all scenarios with CLKS_PER_BIT=16.
1. Byte and back-to-back: DATA_WIDTH=8, PARITY_MODE=0, rx_ready=1; send 0xA5 then 0x3C back-to-back -> two rx_valid pulses, data 0xA5 then 0x3C, all flags 0.
2. Parity: PARITY_MODE=2 (even), send 0x07 with parity bit 1 -> 0x07 delivered, rx_parity_err=0. Same byte with parity bit 0 -> rx_parity_err=1.
3. False start: low glitch of 4 cycles on RXD -> busy rises, returns to IDLE before any bit is sampled, no rx_valid. A 1-cycle glitch inside a data bit at the sample point -> majority vote rejects it, data correct.
4. Framing and break: send 0x55 with stop bit low -> rx_frame_err=1, rx_break=0. Hold RXD low for 20 bit times -> rx_data=0x00, rx_frame_err=1, rx_break=1. busy stays high until RXD returns high, then the next frame 0x81 is received correctly.
5. Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun pulses once. Assert rx_ready -> rx_valid drops next cycle.
6. Disable and reset: deassert enable at data bit 3 -> busy=0 next cycle, no rx_valid. Assert reset mid-frame -> all outputs 0; the next full frame 0xC3 is received correctly.
